// File: rtl/layer_field_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : layer_field_ctrl_if
// Description : Layer stream between the layer generator (master) and the
//               field controller (slave): valid/ready handshake plus one row
//               of block map and block type bits.
// Revision    : 1.0 - initial release
// ============================================================================
interface layer_field_ctrl_if #(
   parameter int LAYER_W = 7
);
   logic               layer_valid;
   logic               layer_ready;
   logic [LAYER_W-1:0] layer_map_in;
   logic [LAYER_W-1:0] block_type_in;

   modport master (
      output layer_valid,
      output layer_map_in,
      output block_type_in,
      input  layer_ready
   );

   modport slave (
      input  layer_valid,
      input  layer_map_in,
      input  block_type_in,
      output layer_ready
   );
endinterface
`default_nettype wire

// File: rtl/layer_field_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : layer_field_ctrl
// Description : Game-field controller. Holds NUM_LAYERS rows of LAYER_W cells,
//               fills them from the layer generator, judges character jumps
//               and scrolls the field by one row per successful jump after a
//               millisecond-timed animation phase.
// Revision    : 1.0 - initial release
// ============================================================================
module layer_field_ctrl #(
   parameter int NUM_LAYERS = 5,
   parameter int LAYER_W    = 7,
   parameter int CHAR_LAYER = 3,
   parameter int START_POS  = 3,
   parameter int SHIFT_MS   = 250,
   parameter int FAIL_EMPTY = 1,
   parameter int SCORE_W    = 10
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             module_en,
   input  logic                             one_ms_tick,
   input  logic                             jump_left,
   input  logic                             jump_right,
   layer_field_ctrl_if.slave                lyr,
   output logic [NUM_LAYERS*LAYER_W-1:0]    field_map,
   output logic [NUM_LAYERS*LAYER_W-1:0]    field_type,
   output logic [$clog2(LAYER_W)-1:0]       char_pos,
   output logic                             shifting,
   output logic [$clog2(SHIFT_MS+1)-1:0]    shift_progress,
   output logic                             jump_fail,
   output logic [1:0]                       fail_cause,
   output logic [SCORE_W-1:0]               score
);

   localparam int c_FW = NUM_LAYERS * LAYER_W;
   localparam int c_CW = $clog2(LAYER_W);
   localparam int c_PW = $clog2(SHIFT_MS + 1);
   localparam int c_NW = $clog2(NUM_LAYERS + 1);

   localparam logic [1:0] c_CAUSE_NONE   = 2'd0;
   localparam logic [1:0] c_CAUSE_HAZARD = 2'd1;
   localparam logic [1:0] c_CAUSE_EMPTY  = 2'd2;
   localparam logic [1:0] c_CAUSE_EDGE   = 2'd3;

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_IDLE   = 3'd1,
      ST_SHIFT  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_FAILED = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [c_NW-1:0]     r_fill;
   logic [c_FW-1:0]     r_map;
   logic [c_FW-1:0]     r_type;
   logic [c_CW-1:0]     r_char;
   logic [c_PW-1:0]     r_prog;
   logic                r_fail;
   logic [1:0]          r_cause;
   logic [SCORE_W-1:0]  r_score;

   logic                w_reset;
   logic                w_ready;
   logic                w_accept;
   logic                w_fill_last;
   logic                w_shift_last;
   logic [LAYER_W-1:0]  w_row_map;
   logic [LAYER_W-1:0]  w_row_type;
   logic                w_jl;
   logic                w_jr;
   logic                w_jump;
   logic                w_edge;
   logic [c_CW-1:0]     w_target;
   logic                w_cell_map;
   logic                w_cell_type;
   logic [1:0]          w_cause;

   // module_en low behaves exactly like rst and overrides everything else
   assign w_reset      = rst || !module_en;
   assign w_ready      = !w_reset && (r_state == ST_INIT || r_state == ST_WAIT);
   assign w_accept     = lyr.layer_valid && w_ready;
   assign w_fill_last  = (r_fill == c_NW'(NUM_LAYERS - 1));
   assign w_shift_last = (r_prog == c_PW'(SHIFT_MS - 1));

   // The landing row is the one just above the character, before any scroll
   assign w_row_map  = r_map[(CHAR_LAYER-1)*LAYER_W +: LAYER_W];
   assign w_row_type = r_type[(CHAR_LAYER-1)*LAYER_W +: LAYER_W];

   // Jump decode and verdict: edge beats hazard beats empty
   always_comb begin
      w_jl        = jump_left && !jump_right;
      w_jr        = jump_right && !jump_left;
      w_jump      = w_jl || w_jr;
      w_target    = w_jl ? (r_char - c_CW'(1)) : (r_char + c_CW'(1));
      w_edge      = (w_jl && (r_char == '0)) ||
                    (w_jr && (r_char == c_CW'(LAYER_W - 1)));
      w_cell_map  = 1'b0;
      w_cell_type = 1'b0;
      if (!w_edge) begin
         w_cell_map  = w_row_map[w_target];
         w_cell_type = w_row_type[w_target];
      end
      w_cause = c_CAUSE_NONE;
      if (w_edge) begin
         w_cause = c_CAUSE_EDGE;
      end else if (w_cell_map && !w_cell_type) begin
         w_cause = c_CAUSE_HAZARD;
      end else if (!w_cell_map && (FAIL_EMPTY != 0)) begin
         w_cause = c_CAUSE_EMPTY;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (w_reset) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_INIT: begin
            if (w_accept && w_fill_last) begin
               w_state_next = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (w_jump) begin
               w_state_next = (w_cause != c_CAUSE_NONE) ? ST_FAILED : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (one_ms_tick && w_shift_last) begin
               w_state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (w_accept) begin
               w_state_next = ST_IDLE;
            end
         end
         ST_FAILED: w_state_next = ST_FAILED;
         default:   w_state_next = ST_INIT;
      endcase
   end

   // Field contents, character, animation timer, verdict and score
   always_ff @(posedge clk) begin
      if (w_reset) begin
         r_fill  <= '0;
         r_map   <= '0;
         r_type  <= '0;
         r_char  <= c_CW'(START_POS);
         r_prog  <= '0;
         r_fail  <= 1'b0;
         r_cause <= c_CAUSE_NONE;
         r_score <= '0;
      end else begin
         if (w_accept) begin
            r_map  <= {r_map[c_FW-LAYER_W-1:0], lyr.layer_map_in};
            r_type <= {r_type[c_FW-LAYER_W-1:0], lyr.block_type_in};
         end
         case (r_state)
            ST_INIT: begin
               if (w_accept) begin
                  r_fill <= w_fill_last ? '0 : (r_fill + c_NW'(1));
               end
            end
            ST_IDLE: begin
               if (w_jump) begin
                  if (w_cause != c_CAUSE_NONE) begin
                     r_fail  <= 1'b1;
                     r_cause <= w_cause;
                  end else begin
                     r_char <= w_target;
                     r_prog <= '0;
                  end
               end
            end
            ST_SHIFT: begin
               if (one_ms_tick) begin
                  r_prog <= w_shift_last ? '0 : (r_prog + c_PW'(1));
               end
            end
            ST_WAIT: begin
               if (w_accept && (r_score != '1)) begin
                  r_score <= r_score + SCORE_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign lyr.layer_ready = w_ready;
   assign field_map       = r_map;
   assign field_type      = r_type;
   assign char_pos        = r_char;
   assign shifting        = (r_state == ST_SHIFT);
   assign shift_progress  = r_prog;
   assign jump_fail       = r_fail;
   assign fail_cause      = r_cause;
   assign score           = r_score;

endmodule
`default_nettype wire

// File: tb/tb_layer_field_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_field_ctrl
// Description : Directed bench for layer_field_ctrl. A second instance with
//               FAIL_EMPTY=0 shares all stimulus to contrast empty-cell rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_field_ctrl;

   localparam int c_W  = 7;
   localparam int c_N  = 5;
   localparam int c_FW = c_N * c_W;

   logic clk = 1'b0;
   logic rst, module_en, tick, jl, jr;

   layer_field_ctrl_if #(.LAYER_W(c_W)) lf ();
   layer_field_ctrl_if #(.LAYER_W(c_W)) lf2 ();

   logic [c_FW-1:0] fmap, ftype, fmap2, ftype2;
   logic [2:0]      cpos, cpos2;
   logic            shf, shf2, jfail, jfail2;
   logic [7:0]      prog, prog2;
   logic [1:0]      cause, cause2;
   logic [9:0]      score, score2;

   assign lf2.layer_valid   = lf.layer_valid;
   assign lf2.layer_map_in  = lf.layer_map_in;
   assign lf2.block_type_in = lf.block_type_in;

   layer_field_ctrl dut (
      .clk(clk), .rst(rst), .module_en(module_en), .one_ms_tick(tick),
      .jump_left(jl), .jump_right(jr), .lyr(lf),
      .field_map(fmap), .field_type(ftype), .char_pos(cpos), .shifting(shf),
      .shift_progress(prog), .jump_fail(jfail), .fail_cause(cause), .score(score)
   );

   layer_field_ctrl #(.FAIL_EMPTY(0)) dut_ne (
      .clk(clk), .rst(rst), .module_en(module_en), .one_ms_tick(tick),
      .jump_left(jl), .jump_right(jr), .lyr(lf2),
      .field_map(fmap2), .field_type(ftype2), .char_pos(cpos2), .shifting(shf2),
      .shift_progress(prog2), .jump_fail(jfail2), .fail_cause(cause2), .score(score2)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int acc_cnt = 0;

   logic [2*c_W-1:0] q_lay[$];
   logic [c_FW-1:0]  m_map, m_type;
   logic [c_W-1:0]   a_map[5];
   logic [c_W-1:0]   a_type[5];

   // Count handshakes independently of the stimulus tasks
   always @(posedge clk) begin
      if (lf.layer_valid && lf.layer_ready) acc_cnt <= acc_cnt + 1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one layer; expected row pushed on drive, popped on handshake
   task automatic send_layer(input logic [c_W-1:0] m, input logic [c_W-1:0] t, input int gap);
      logic [2*c_W-1:0] e;
      int w;
      q_lay.push_back({m, t});
      lf.layer_valid = 1'b0;
      repeat (gap) @(negedge clk);
      lf.layer_map_in  = m;
      lf.block_type_in = t;
      lf.layer_valid   = 1'b1;
      w = 0;
      #1;
      while (!lf.layer_ready && w < 100) begin
         @(negedge clk);
         #1;
         w++;
      end
      if (!lf.layer_ready) begin
         n_tests++;
         n_fail++;
         $error("FAIL accept_timeout: observed ready=0 expected ready=1 within 100 cycles");
         void'(q_lay.pop_front());
      end else begin
         e = q_lay.pop_front();
         m_map  = {m_map[c_FW-c_W-1:0], e[2*c_W-1:c_W]};
         m_type = {m_type[c_FW-c_W-1:0], e[c_W-1:0]};
      end
      @(negedge clk);
      lf.layer_valid = 1'b0;
   endtask

   task automatic fill5();
      for (int i = 0; i < 5; i++) send_layer(a_map[i], a_type[i], i % 4);
   endtask

   task automatic do_jump(input logic l, input logic r);
      jl = l;
      jr = r;
      @(negedge clk);
      jl = 1'b0;
      jr = 1'b0;
   endtask

   task automatic ticks(input int n);
      tick = 1'b1;
      repeat (n) @(negedge clk);
      tick = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; module_en = 1'b1; tick = 1'b0; jl = 1'b0; jr = 1'b0;
      lf.layer_valid = 1'b0; lf.layer_map_in = '0; lf.block_type_in = '0;
      m_map = '0; m_type = '0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_ready", lf.layer_ready, 0);
      check("rst_map", fmap, 0);
      check("rst_char", cpos, 3);
      check("rst_score", score, 0);
      check("rst_fail", {jfail, cause}, 0);
      check("rst_shift", {shf, prog}, 0);
      rst = 1'b0;
      #1;
      check("init_ready", lf.layer_ready, 1);
      @(negedge clk);

      // Initial fill with 0..3 cycle gaps
      a_map  = '{7'b1010101, 7'b0110011, 7'b0010000, 7'b1111111, 7'b0001000};
      a_type = '{7'b1110000, 7'b0100001, 7'b0010000, 7'b1111111, 7'b0001000};
      fill5();
      check("fill_accepts", acc_cnt, 5);
      check("fill_map", fmap, m_map);
      check("fill_type", ftype, m_type);
      check("fill_row4", fmap[4*c_W +: c_W], 7'b1010101);
      check("fill_idle_ready", lf.layer_ready, 0);
      check("fill_char", cpos, 3);

      // Both jumps at once: no action
      do_jump(1'b1, 1'b1);
      check("both_char", cpos, 3);
      check("both_state", {shf, jfail, lf.layer_ready}, 0);

      // Successful right jump, animation, scroll
      do_jump(1'b0, 1'b1);
      check("jr_char", cpos, 4);
      check("jr_shift", {shf, prog}, {1'b1, 8'd0});
      do_jump(1'b1, 1'b0);
      check("shift_jump_ignored", {cpos, shf, jfail}, {3'd4, 1'b1, 1'b0});
      ticks(100);
      check("prog_100", prog, 100);
      ticks(149);
      check("prog_249", {shf, prog}, {1'b1, 8'd249});
      ticks(1);
      check("shift_done", {shf, prog}, 0);
      check("wait_ready", lf.layer_ready, 1);
      repeat (50) @(negedge clk);
      check("wait_hold", {lf.layer_ready, shf, score}, {1'b1, 1'b0, 10'd0});
      jl = 1'b1;
      send_layer(7'b1100110, 7'b1000100, 0);
      jl = 1'b0;
      check("scroll_score", score, 1);
      check("scroll_map", fmap, m_map);
      check("scroll_type", ftype, m_type);
      check("scroll_row3", fmap[3*c_W +: c_W], 7'b0010000);
      check("scroll_idle", {cpos, shf, lf.layer_ready, jfail}, {3'd4, 3'b000});

      // Reset in the middle of an animation
      do_jump(1'b0, 1'b1);
      check("jr2_char", {cpos, shf}, {3'd5, 1'b1});
      ticks(100);
      check("jr2_prog", prog, 100);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_field", {fmap, ftype}, 0);
      check("midrst_state", {shf, prog, score, jfail}, 0);
      check("midrst_char", cpos, 3);
      rst = 1'b0;
      #1;
      check("midrst_init", lf.layer_ready, 1);
      @(negedge clk);
      m_map = '0; m_type = '0;

      // Hazard landing
      a_map  = '{7'b1111111, 7'b1111111, 7'b0010100, 7'b1111111, 7'b1111111};
      a_type = '{7'b1111111, 7'b1111111, 7'b0010000, 7'b1111111, 7'b1111111};
      fill5();
      check("hz_fill", fmap, m_map);
      do_jump(1'b1, 1'b0);
      check("hz_fail", {jfail, cause}, {1'b1, 2'd1});
      check("hz_char", {cpos, shf}, {3'd3, 1'b0});
      do_jump(1'b0, 1'b1);
      check("hz_absorb", {jfail, cause, cpos}, {1'b1, 2'd1, 3'd3});
      lf.layer_valid = 1'b1;
      repeat (3) @(negedge clk);
      check("hz_no_ready", lf.layer_ready, 0);
      lf.layer_valid = 1'b0;
      check("hz_frozen", {fmap, score}, {m_map, 10'd0});
      module_en = 1'b0;
      @(negedge clk);
      check("en_clear", {jfail, cause, fmap}, 0);
      module_en = 1'b1;
      @(negedge clk);
      m_map = '0; m_type = '0;

      // Walk to column 0 then hit the left edge
      a_map  = '{7'b1111111, 7'b1111111, 7'b0000100, 7'b0000010, 7'b0000001};
      a_type = a_map;
      fill5();
      for (int i = 0; i < 3; i++) begin
         do_jump(1'b1, 1'b0);
         ticks(250);
         send_layer(7'b1111111, 7'b1111111, 0);
      end
      check("walk_char", {cpos, shf}, {3'd0, 1'b0});
      check("walk_score", score, 3);
      do_jump(1'b1, 1'b0);
      check("edge_fail", {jfail, cause, cpos}, {1'b1, 2'd3, 3'd0});
      check("edge_fail_ne", {jfail2, cause2}, {1'b1, 2'd3});
      module_en = 1'b0;
      @(negedge clk);
      module_en = 1'b1;
      @(negedge clk);
      m_map = '0; m_type = '0;

      // Empty target: fail with FAIL_EMPTY=1, pass with FAIL_EMPTY=0
      a_map  = '{7'b1111111, 7'b1111111, 7'b1111011, 7'b1111111, 7'b1111111};
      a_type = '{7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
      fill5();
      do_jump(1'b1, 1'b0);
      check("empty_fail", {jfail, cause, cpos}, {1'b1, 2'd2, 3'd3});
      check("empty_pass_ne", {jfail2, cause2, cpos2, shf2}, {1'b0, 2'd0, 3'd2, 1'b1});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
